// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: controller
// states, pipeline register indices, redirect target selectors and the
// helper that computes the back-pressure allow chain.
package pipe_ctrl_pkg;

    // Number of pipeline registers under control (reg_1_2 .. WB latch)
    localparam int NSTG = 5;

    // Bit index of each pipeline register inside the per-stage vectors
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    // Redirect target selectors presented to the fetch unit
    localparam logic REDIR_EXC = 1'b0;
    localparam logic REDIR_EPC = 1'b1;

    // Controller states
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MD_WAIT = 2'b01,
        ST_FLUSH   = 2'b10,
        ST_REDIR   = 2'b11
    } pipe_state_t;

    // Back-pressure chain: the WB latch always loads, and register k may
    // load only when register k+1 is empty or finishing and itself may load.
    // Only registers 1..4 influence the chain, so only those bits are taken.
    function automatic logic [NSTG-1:0] run_allow(input logic [NSTG-1:1] valid_up,
                                                  input logic [NSTG-1:1] done_up);
        logic [NSTG-1:0] a;
        a = '0;
        a[NSTG-1] = 1'b1;
        for (int k = NSTG - 2; k >= 0; k--) begin
            a[k] = (~valid_up[k+1] | done_up[k+1]) & a[k+1];
        end
        return a;
    endfunction

endpackage

// File: rtl/pipe_md_timer.sv
// Loadable down-counter that times how long EX is held for the multi-cycle
// mul/div unit. A load takes priority over counting; counting stops at zero.
module pipe_md_timer #(
    parameter int W = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Count register: cleared on reset, reloaded on load, else counts down
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Produces the
// per-register allow_in/flush vectors, holds EX while the mul/div unit
// works, and runs the exception/ERET redirect handshake with fetch.
// Optional build macro PIPE_CTRL_PERF_EN adds saturating stall/flush
// performance counters on two extra output ports.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LAT = 34
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NSTG-1:0] stg_valid,
    input  logic [NSTG-1:0] stg_done,
    input  logic            load_use,
    input  logic            md_start,
    input  logic            wb_ex,
    input  logic            wb_eret,
    input  logic            redir_ready,
    output logic [NSTG-1:0] allow_in,
    output logic [NSTG-1:0] flush,
    output logic            redir_valid,
    output logic            redir_sel,
    output logic            busy_md
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_stall,
    output logic [15:0]     perf_flush
`endif
);

    // Timer width holds MD_LAT-1; the hold lasts MD_LAT cycles in total
    localparam int CW = (MD_LAT < 2) ? 1 : $clog2(MD_LAT);
    localparam logic [CW-1:0] MD_LOAD = CW'(MD_LAT - 1);

    pipe_state_t     state;
    logic            take_redir;
    logic            redir_sel_next;
    logic            md_load;
    logic            md_clear;
    logic            tmr_load;
    logic [CW-1:0]   tmr_value;
    logic            md_zero;
    logic [NSTG-1:0] chain;
    logic            unused_stg;

    // Register 1_2 has nothing upstream to gate, so its own status is unused
    assign unused_stg = stg_valid[STG_IF] ^ stg_done[STG_IF];

    // An exception or ERET in WB is the single redirect decision point;
    // when both are seen together the exception wins
    assign take_redir     = wb_ex | wb_eret;
    assign redir_sel_next = wb_ex ? REDIR_EXC : (wb_eret ? REDIR_EPC : REDIR_EXC);

    // Timer is loaded when a mul/div issues in RUN and cleared when a
    // redirect aborts the hold
    assign md_load   = (state == ST_RUN) && !take_redir && md_start;
    assign md_clear  = (state == ST_MD_WAIT) && take_redir;
    assign tmr_load  = md_load | md_clear;
    assign tmr_value = md_clear ? '0 : MD_LOAD;

    pipe_md_timer #(
        .W (CW)
    ) u_md_timer (
        .clock (clock),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_value),
        .dec   (state == ST_MD_WAIT),
        .zero  (md_zero)
    );

    assign chain = run_allow(stg_valid[NSTG-1:1], stg_done[NSTG-1:1]);

    // Controller state and the latched redirect target
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_RUN;
            redir_sel <= REDIR_EXC;
        end else begin
            case (state)
                ST_RUN: begin
                    if (take_redir) begin
                        state     <= ST_FLUSH;
                        redir_sel <= redir_sel_next;
                    end else if (md_start) begin
                        state <= ST_MD_WAIT;
                    end
                end
                ST_MD_WAIT: begin
                    if (take_redir) begin
                        state     <= ST_FLUSH;
                        redir_sel <= redir_sel_next;
                    end else if (md_zero) begin
                        state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_REDIR;
                end
                ST_REDIR: begin
                    if (redir_ready) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Per-register load/flush, redirect request and hold flag from state
    always_comb begin
        allow_in    = '0;
        flush       = '0;
        redir_valid = 1'b0;
        busy_md     = 1'b0;
        if (reset) begin
            flush = '1;
        end else begin
            case (state)
                ST_RUN: begin
                    allow_in = chain;
                    if (load_use) begin
                        allow_in[STG_ID:STG_IF] = 2'b00;
                        flush[STG_EX]           = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    allow_in[STG_WB:STG_MEM] = chain[STG_WB:STG_MEM];
                    flush[STG_MEM]           = 1'b1;
                    busy_md                  = 1'b1;
                end
                ST_FLUSH: begin
                    allow_in = '1;
                    flush    = '1;
                end
                ST_REDIR: begin
                    redir_valid = 1'b1;
                end
                default: begin
                    flush = '1;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Saturating counts of front-end stall cycles and flush entries
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            if (((state == ST_RUN) || (state == ST_MD_WAIT)) && !allow_in[STG_IF]
                && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 1'b1;
            end
            if ((state == ST_FLUSH) && (perf_flush != '1)) begin
                perf_flush <= perf_flush + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver applies directed and random
// stimulus, predicts outputs from a behavioural model and queues them;
// a monitor on the falling edge pops and compares, and separately matches
// every accepted redirect against a queue of expected redirect targets.
module tb_pipe_ctrl;

    localparam int MD_LAT = 4;
    localparam int M_RUN = 0, M_MD = 1, M_FLUSH = 2, M_REDIR = 3;

    typedef struct packed {
        logic [4:0] allow;
        logic [4:0] flsh;
        logic       rv;
        logic       busy;
        logic       sel;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] stg_valid = '0;
    logic [4:0] stg_done = '0;
    logic       load_use = 1'b0;
    logic       md_start = 1'b0;
    logic       wb_ex = 1'b0;
    logic       wb_eret = 1'b0;
    logic       redir_ready = 1'b0;
    logic [4:0] allow_in;
    logic [4:0] flush;
    logic       redir_valid;
    logic       redir_sel;
    logic       busy_md;

    exp_t exp_q[$];
    logic redir_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    int   m_mode = M_RUN;
    int   m_hold = 0;
    logic m_sel = 1'b0;
    logic p_rst = 1'b1, p_ms = 1'b0, p_ex = 1'b0, p_er = 1'b0, p_rr = 1'b0;

    pipe_ctrl #(.MD_LAT(MD_LAT)) dut (
        .clock       (clock),
        .reset       (reset),
        .stg_valid   (stg_valid),
        .stg_done    (stg_done),
        .load_use    (load_use),
        .md_start    (md_start),
        .wb_ex       (wb_ex),
        .wb_eret     (wb_eret),
        .redir_ready (redir_ready),
        .allow_in    (allow_in),
        .flush       (flush),
        .redir_valid (redir_valid),
        .redir_sel   (redir_sel),
        .busy_md     (busy_md)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle: advance the model over the edge, then drive and predict
    task automatic applyStimulus(input logic rst, input logic [4:0] v, input logic [4:0] d,
                                 input logic lu, input logic ms, input logic ex,
                                 input logic er, input logic rr);
        exp_t e;
        @(posedge clock);
        #1;
        if (p_rst) begin
            m_mode = M_RUN; m_hold = 0; m_sel = 1'b0;
        end else begin
            case (m_mode)
                M_RUN: begin
                    if (p_ex || p_er) begin
                        m_mode = M_FLUSH; m_sel = p_er && !p_ex;
                    end else if (p_ms) begin
                        m_mode = M_MD; m_hold = MD_LAT;
                    end
                end
                M_MD: begin
                    m_hold = m_hold - 1;
                    if (p_ex || p_er) begin
                        m_mode = M_FLUSH; m_sel = p_er && !p_ex; m_hold = 0;
                    end else if (m_hold == 0) begin
                        m_mode = M_RUN;
                    end
                end
                M_FLUSH: m_mode = M_REDIR;
                default: if (p_rr) m_mode = M_RUN;
            endcase
        end

        reset = rst; stg_valid = v; stg_done = d; load_use = lu;
        md_start = ms; wb_ex = ex; wb_eret = er; redir_ready = rr;

        e = '0;
        e.sel = m_sel;
        if (rst) begin
            e.flsh = 5'b11111;
        end else if (m_mode == M_FLUSH) begin
            e.allow = 5'b11111; e.flsh = 5'b11111;
        end else if (m_mode == M_REDIR) begin
            e.rv = 1'b1;
            if (rr) redir_q.push_back(m_sel);
        end else begin
            // register k may load only if no stage above it is occupied and stuck
            for (int k = 0; k < 5; k++) begin
                e.allow[k] = 1'b1;
                for (int j = k + 1; j < 5; j++)
                    if (v[j] && !d[j]) e.allow[k] = 1'b0;
            end
            if (m_mode == M_MD) begin
                e.allow[2:0] = 3'b000; e.flsh = 5'b01000; e.busy = 1'b1;
            end else if (lu) begin
                e.allow[1:0] = 2'b00; e.flsh = 5'b00100;
            end
        end
        exp_q.push_back(e);
        mon_en = 1'b1;
        p_rst = rst; p_ms = ms; p_ex = ex; p_er = er; p_rr = rr;
    endtask

    // Monitor: compare every presented cycle and every accepted redirect
    always @(negedge clock) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checkOutput("exp_queue_underflow", 8'd0, 8'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("allow_in", {3'b0, allow_in}, {3'b0, e.allow});
                checkOutput("flush", {3'b0, flush}, {3'b0, e.flsh});
                checkOutput("redir_valid", {7'b0, redir_valid}, {7'b0, e.rv});
                checkOutput("busy_md", {7'b0, busy_md}, {7'b0, e.busy});
                checkOutput("redir_sel", {7'b0, redir_sel}, {7'b0, e.sel});
            end
            if (redir_valid && redir_ready) begin
                if (redir_q.size() == 0) begin
                    checkOutput("unexpected_redirect", 8'd1, 8'd0);
                end else begin
                    logic s;
                    s = redir_q.pop_front();
                    checkOutput("redirect_target", {7'b0, redir_sel}, {7'b0, s});
                end
            end
        end
    end

    initial begin
        $display("[TB] start, MD_LAT=%0d", MD_LAT);
        // reset
        repeat (2) applyStimulus(1, 5'h1f, 5'h1f, 0, 0, 0, 0, 0);
        // full flow
        repeat (4) applyStimulus(0, 5'h1f, 5'h1f, 0, 0, 0, 0, 0);
        // MEM not done for three cycles
        repeat (3) applyStimulus(0, 5'h1f, 5'h17, 0, 0, 0, 0, 0);
        applyStimulus(0, 5'h1f, 5'h1f, 0, 0, 0, 0, 0);
        // load-use bubble
        applyStimulus(0, 5'h1f, 5'h1f, 1, 0, 0, 0, 0);
        repeat (2) applyStimulus(0, 5'h1f, 5'h1f, 0, 0, 0, 0, 0);
        // mul/div hold
        applyStimulus(0, 5'h1f, 5'h1f, 0, 1, 0, 0, 0);
        repeat (MD_LAT + 2) applyStimulus(0, 5'h1f, 5'h1f, 0, 0, 0, 0, 0);
        // exception beats md_start, fetch stalls the redirect
        applyStimulus(0, 5'h1f, 5'h1f, 1, 1, 1, 0, 0);
        repeat (4) applyStimulus(0, 5'h1f, 5'h1f, 0, 0, 0, 0, 0);
        applyStimulus(0, 5'h1f, 5'h1f, 0, 0, 0, 0, 1);
        repeat (2) applyStimulus(0, 5'h1f, 5'h1f, 0, 0, 0, 0, 0);
        // exception aborting a mul/div hold
        applyStimulus(0, 5'h1f, 5'h1f, 0, 1, 0, 0, 0);
        applyStimulus(0, 5'h1f, 5'h1f, 0, 0, 0, 0, 0);
        applyStimulus(0, 5'h1f, 5'h1f, 0, 0, 1, 0, 0);
        repeat (3) applyStimulus(0, 5'h1f, 5'h1f, 0, 0, 0, 0, 1);
        // ERET, then reset while in REDIR
        applyStimulus(0, 5'h1f, 5'h1f, 0, 0, 0, 1, 0);
        repeat (3) applyStimulus(0, 5'h1f, 5'h1f, 0, 0, 0, 0, 0);
        repeat (2) applyStimulus(1, 5'h1f, 5'h1f, 0, 0, 0, 0, 1);
        applyStimulus(0, 5'h1f, 5'h1f, 0, 0, 0, 0, 0);
        // both exception and ERET together
        applyStimulus(0, 5'h1f, 5'h1f, 0, 0, 1, 1, 0);
        repeat (3) applyStimulus(0, 5'h1f, 5'h1f, 0, 0, 0, 0, 1);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          5'($urandom), 5'($urandom),
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 6) == 0,
                          $urandom_range(0, 24) == 0,
                          $urandom_range(0, 24) == 0,
                          $urandom_range(0, 1) == 1);
        end
        @(negedge clock);
        #1;
        checkOutput("exp_queue_drained", 8'(exp_q.size()), 8'd0);
        checkOutput("redirects_all_seen", 8'(redir_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
